gpio_input_debounce: RTL and testbench
======================================

Name: gpio_input_debounce

Overview:
- Downstream consumer of the I2C I/O-expander driver's polled input ports: button bits and GPIO port readback.
- Raw expander samples can flicker between polls due to contact bounce and re-reads.
- This block filters each bit with a tick-based debounce counter and presents stable levels plus one-cycle rise/fall event pulses to core logic.
- Gates everything on the expander's present flag, so an absent or unplugged device never generates events.

Parameters:
- WIDTH, 8, number of input bits filtered (one independent channel per bit).
- TICK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz); must be >= 2.
- DEBOUNCE_TICKS, 5, consecutive ticks a new value must persist before acceptance; must be >= 1.
- INVERT, {WIDTH{1'b0}}, per-bit XOR mask applied to raw_in (1 = active-low input with pull-up).
- IDLE_VAL, {WIDTH{1'b0}}, logical stable value forced while present is low.

Ports:
- clk  input  1  core clock; single clock domain.
- reset_n  input  1  asynchronous active-low reset.
- present  input  1  expander present flag from the driver.
- raw_in  input  WIDTH  polled input bits; same clk domain, already registered, no synchroniser.
- stable  output  WIDTH  debounced logical level.
- rise  output  WIDTH  one-cycle pulse per bit on a stable 0->1 transition.
- fall  output  WIDTH  one-cycle pulse per bit on a stable 1->0 transition.
- changed  output  1  sticky flag: any rise/fall has occurred since the last ack.
- changed_ack  input  1  single-cycle clear of changed.

Behaviour:
- Reset (async assert, sync release) sets:
  - stable = IDLE_VAL; rise = fall = 0; changed = 0.
  - prescaler = 0; all per-bit counters = 0; resync = 1.
- Logical input: lin = raw_in ^ INVERT (combinational).
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is high on the cycle where count == TICK_DIV-1.
  - Free-runs regardless of present.
- Per-bit counter: width clog2(DEBOUNCE_TICKS+1); saturates at DEBOUNCE_TICKS and never wraps.
- State NOPRES (present == 0):
  - stable <= IDLE_VAL on every cycle; counters <= 0; resync <= 1.
  - rise/fall held 0, so a present drop produces no events.
  - Effect is registered: visible 1 cycle after present falls.
- State RESYNC (present == 1 and resync == 1):
  - Waits for the next tick.
  - On that tick: stable <= lin; counters <= 0; resync <= 0; no rise/fall pulses.
  - Device arrival never fires events.
- State RUN (present == 1 and resync == 0), per bit on each tick:
  - lin == stable: counter <= 0.
  - lin != stable and counter + 1 < DEBOUNCE_TICKS: counter <= counter + 1.
  - lin != stable and counter + 1 == DEBOUNCE_TICKS: stable <= lin, counter <= 0, and rise (if lin = 1) or fall (if lin = 0) pulses high for exactly 1 cycle.
- Between ticks: counters and stable hold; rise/fall are 0.
- Any reversion of lin to stable seen on a tick restarts that bit's count (glitch rejection). Changes that come and go entirely between ticks are ignored.
- Latency: a clean edge is accepted on the DEBOUNCE_TICKS-th tick at which it is observed. stable/rise/fall update the cycle after that tick. Worst case (DEBOUNCE_TICKS+1)*TICK_DIV + 1 clk.
- Multiple bits may transition on the same tick; each pulses independently.
- changed:
  - Set on any cycle where (rise | fall) != 0.
  - Cleared by changed_ack.
  - Set and ack on the same cycle: set wins, changed stays 1.
- present falling mid-count: counts are discarded, and no partial acceptance occurs.

Test Plan:
- Reset:
  - Stimulus: WIDTH = 8, IDLE_VAL = 0x00; assert reset_n = 0 mid-simulation with present = 1 and raw_in = 0xFF.
  - Required: stable = 0x00, rise = fall = 0x00, changed = 0 asynchronously, before the next clk edge.
- Clean press:
  - Stimulus: TICK_DIV = 4, DEBOUNCE_TICKS = 3; present = 1 and resync done with raw_in = 0x00; then raw_in = 0x01 held.
  - Required: stable = 0x01 on the third tick after the change (<= 17 clk); rise = 0x01 for exactly 1 cycle; fall = 0; changed = 1.
- Glitch rejection:
  - Stimulus: raw_in bit1 high for 2 ticks, then low.
  - Required: stable stays 0x00, no rise/fall pulses, changed unchanged.
- Present handling:
  - Stimulus: present 1->0 with stable = 0x01; later present 0->1 with raw_in = 0xA5.
  - Required: stable = 0x00 one cycle after the drop, with no fall pulse. stable = 0xA5 at the first tick after present returns, with rise = 0.
- Ack collision:
  - Stimulus: changed_ack = 1 on the same cycle a fall pulse occurs.
  - Required: changed remains 1. A subsequent lone ack clears it to 0.
- Inversion:
  - Stimulus: INVERT = 0xFF; raw_in = 0xFE held for >= DEBOUNCE_TICKS ticks after resync from raw_in = 0xFF.
  - Required: stable = 0x01; rise = 0x01 for 1 cycle.

Source files
------------

// File: rtl/gpio_input_debounce.sv
// gpio_input_debounce: per-bit tick-based debounce filter for polled I/O-expander
// inputs. Presents stable levels, one-cycle rise/fall pulses and a sticky changed
// flag. While the expander is absent everything is held at IDLE_VAL and no events fire.
//
// Handshake: changed_ack is a single-cycle clear strobe with no ready side; a
// pulse seen on the same cycle as the ack takes priority so no event is lost.
module gpio_input_debounce #(
   parameter int               WIDTH          = 8,
   parameter int               TICK_DIV       = 50000,
   parameter int               DEBOUNCE_TICKS = 5,
   parameter logic [WIDTH-1:0] INVERT         = '0,
   parameter logic [WIDTH-1:0] IDLE_VAL       = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             present,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] stable,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed,
   input  logic             changed_ack
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;

   // Operating mode, decoded from present and the resync register. Kept as a
   // named signal so checkers can bind to it.
   typedef enum logic [1:0] {
      ST_NOPRES = 2'd0,
      ST_RESYNC = 2'd1,
      ST_RUN    = 2'd2
   } mode_e;

   mode_e            mode;
   logic [PW-1:0]    pre_q, pre_d;
   logic             tick;
   logic [WIDTH-1:0] lin;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic             changed_q, changed_d;
   logic             resync_q, resync_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];

   assign lin  = raw_in ^ INVERT;
   assign tick = (pre_q == PW'(TICK_DIV - 1));

   // Mode decode: absence overrides everything, then the pending resync.
   always_comb begin
      mode = ST_RUN;
      if (!present)     mode = ST_NOPRES;
      else if (resync_q) mode = ST_RESYNC;
   end

   // Free-running prescaler, independent of present.
   always_comb begin
      pre_d = tick ? '0 : pre_q + PW'(1);
   end

   // Per-bit filter next state. Counters only move on ticks; pulses last one cycle.
   always_comb begin
      stable_d = stable_q;
      rise_d   = '0;
      fall_d   = '0;
      resync_d = resync_q;
      for (int i = 0; i < WIDTH; i++) cnt_d[i] = cnt_q[i];
      case (mode)
         ST_NOPRES: begin
            stable_d = IDLE_VAL;
            resync_d = 1'b1;
            for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
         end
         ST_RESYNC: begin
            if (tick) begin
               // Adopt the current level silently: device arrival is not an event.
               stable_d = lin;
               resync_d = 1'b0;
               for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
            end
         end
         default: begin
            if (tick) begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (lin[i] == stable_q[i]) begin
                     cnt_d[i] = '0;
                  end else if ((int'(cnt_q[i]) + 1) < DEBOUNCE_TICKS) begin
                     cnt_d[i] = cnt_q[i] + CW'(1);
                  end else begin
                     stable_d[i] = lin[i];
                     cnt_d[i]    = '0;
                     rise_d[i]   = lin[i];
                     fall_d[i]   = ~lin[i];
                  end
               end
            end
         end
      endcase
   end

   // Sticky change flag: a visible pulse wins over a simultaneous ack.
   always_comb begin
      changed_d = changed_q;
      if ((rise_q | fall_q) != '0) changed_d = 1'b1;
      else if (changed_ack)        changed_d = 1'b0;
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q     <= '0;
         stable_q  <= IDLE_VAL;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
         resync_q  <= 1'b1;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         pre_q     <= pre_d;
         stable_q  <= stable_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
         resync_q  <= resync_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign stable  = stable_q;
   assign rise    = rise_q;
   assign fall    = fall_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Directed bench for gpio_input_debounce with TICK_DIV=4, DEBOUNCE_TICKS=3.
// After reset release the prescaler ticks are sampled on edges 4, 8, 12, ...
// (edge numbers counted from the first posedge after release).
module tb_gpio_input_debounce;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         present;
   logic [W-1:0] raw_in;
   logic [W-1:0] raw_inv;
   logic         changed_ack;
   logic         ack_inv;

   logic [W-1:0] stable, rise, fall;
   logic         changed;
   logic [W-1:0] stable_inv, rise_inv, fall_inv;
   logic         changed_inv;

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;

   gpio_input_debounce #(
      .WIDTH(W), .TICK_DIV(4), .DEBOUNCE_TICKS(3),
      .INVERT(8'h00), .IDLE_VAL(8'h00)
   ) dut (
      .clk(clk), .reset_n(reset_n), .present(present), .raw_in(raw_in),
      .stable(stable), .rise(rise), .fall(fall),
      .changed(changed), .changed_ack(changed_ack)
   );

   gpio_input_debounce #(
      .WIDTH(W), .TICK_DIV(4), .DEBOUNCE_TICKS(3),
      .INVERT(8'hFF), .IDLE_VAL(8'h00)
   ) dut_inv (
      .clk(clk), .reset_n(reset_n), .present(present), .raw_in(raw_inv),
      .stable(stable_inv), .rise(rise_inv), .fall(fall_inv),
      .changed(changed_inv), .changed_ack(ack_inv)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // Advance n posedges, then settle 1 ns past the edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         edge_n++;
      end
      #1;
   endtask

   task automatic goto_edge(input int e);
      if (e > edge_n) cyc(e - edge_n);
   endtask

   initial begin
      reset_n     = 1'b0;
      present     = 1'b1;
      raw_in      = 8'h00;
      raw_inv     = 8'hFF;
      changed_ack = 1'b0;
      ack_inv     = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_stable", 32'(stable), 32'h00);
      check("rst_changed", 32'(changed), 32'h0);
      reset_n = 1'b1;
      edge_n  = 0;

      // Resync at edge 4 adopts 0x00 (inverted instance: 0xFF^0xFF = 0x00).
      goto_edge(4);
      check("resync_stable", 32'(stable), 32'h00);
      check("resync_rise", 32'(rise), 32'h00);
      check("inv_resync_stable", 32'(stable_inv), 32'h00);

      // Clean press: accepted on ticks 8, 12, 16 -> visible after edge 16.
      raw_in  = 8'h01;
      raw_inv = 8'hFE;
      goto_edge(12);
      check("press_mid_stable", 32'(stable), 32'h00);
      goto_edge(15);
      check("press_pre_stable", 32'(stable), 32'h00);
      check("press_pre_rise", 32'(rise), 32'h00);
      check("inv_pre_stable", 32'(stable_inv), 32'h00);
      goto_edge(16);
      check("press_stable", 32'(stable), 32'h01);
      check("press_rise", 32'(rise), 32'h01);
      check("press_fall", 32'(fall), 32'h00);
      check("inv_stable", 32'(stable_inv), 32'h01);
      check("inv_rise", 32'(rise_inv), 32'h01);
      goto_edge(17);
      check("press_rise_end", 32'(rise), 32'h00);
      check("press_changed", 32'(changed), 32'h1);
      check("inv_rise_end", 32'(rise_inv), 32'h00);

      // Glitch: bit1 high over ticks 20 and 24 only; bit2 pulse between ticks.
      raw_in = 8'h03;
      goto_edge(24);
      raw_in = 8'h01;
      goto_edge(28);
      raw_in = 8'h05;
      goto_edge(30);
      raw_in = 8'h01;
      for (int e = 31; e <= 36; e++) begin
         goto_edge(e);
         check("glitch_stable", 32'(stable), 32'h01);
         check("glitch_pulses", 32'(rise | fall), 32'h00);
      end
      check("glitch_changed", 32'(changed), 32'h1);

      // Release: accepted on ticks 40, 44, 48 -> fall visible after edge 48.
      raw_in = 8'h00;
      goto_edge(47);
      check("rel_pre_stable", 32'(stable), 32'h01);
      check("rel_pre_fall", 32'(fall), 32'h00);
      goto_edge(48);
      check("rel_stable", 32'(stable), 32'h00);
      check("rel_fall", 32'(fall), 32'h01);
      check("rel_rise", 32'(rise), 32'h00);
      // Ack on the same cycle the fall pulse is visible: set wins.
      changed_ack = 1'b1;
      goto_edge(49);
      changed_ack = 1'b0;
      check("collide_changed", 32'(changed), 32'h1);
      check("collide_fall_end", 32'(fall), 32'h00);
      goto_edge(50);
      changed_ack = 1'b1;
      goto_edge(51);
      changed_ack = 1'b0;
      check("lone_ack_changed", 32'(changed), 32'h0);

      // Press again so stable = 0x01: ticks 52, 56, 60.
      raw_in = 8'h01;
      goto_edge(60);
      check("press2_stable", 32'(stable), 32'h01);
      check("press2_rise", 32'(rise), 32'h01);
      goto_edge(62);
      check("press2_changed", 32'(changed), 32'h1);

      // Present drop: idle value one cycle later, no fall pulse.
      present = 1'b0;
      goto_edge(63);
      check("drop_stable", 32'(stable), 32'h00);
      check("drop_fall", 32'(fall), 32'h00);
      changed_ack = 1'b1;
      goto_edge(64);
      changed_ack = 1'b0;
      check("drop_fall2", 32'(fall), 32'h00);
      check("drop_ack_changed", 32'(changed), 32'h0);
      goto_edge(65);
      check("drop_stable2", 32'(stable), 32'h00);

      // Return with 0xA5: adopted silently on the tick at edge 68.
      present = 1'b1;
      raw_in  = 8'hA5;
      goto_edge(67);
      check("ret_pre_stable", 32'(stable), 32'h00);
      goto_edge(68);
      check("ret_stable", 32'(stable), 32'hA5);
      check("ret_rise", 32'(rise), 32'h00);
      check("ret_fall", 32'(fall), 32'h00);
      goto_edge(69);
      check("ret_changed", 32'(changed), 32'h0);
      check("ret_rise2", 32'(rise), 32'h00);

      // Multi-bit: 0xA5 -> 0xFF rises bits 0x5A together on ticks 72, 76, 80.
      raw_in = 8'hFF;
      goto_edge(80);
      check("multi_stable", 32'(stable), 32'hFF);
      check("multi_rise", 32'(rise), 32'h5A);
      check("multi_fall", 32'(fall), 32'h00);
      goto_edge(81);
      check("multi_changed", 32'(changed), 32'h1);

      // Asynchronous reset mid-cycle with present=1, raw_in=0xFF.
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_stable", 32'(stable), 32'h00);
      check("arst_rise", 32'(rise), 32'h00);
      check("arst_fall", 32'(fall), 32'h00);
      check("arst_changed", 32'(changed), 32'h0);
      repeat (2) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
